rob_wb_arbiter: RTL and testbench

- Shares the ROB's single writeback port between two requesters: the ALU writeback (result plus branch npc/mispredict) and the load writeback.
- Each requester has a 2-entry queue with ready/valid backpressure.
- Arbitration gives loads priority. A starvation counter guarantees that the ALU gets a grant.
- Sits between the execute units and the ROB. A branch-mispredict redirect (`flush`) clears all pending writebacks.

---
 rtl/rob_wb_arbiter_if.sv | 49 ++++
 rtl/rob_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rob_wb_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rob_wb_arbiter_if.sv
// Bundles the ALU writeback, load writeback and ROB writeback handshakes.
// The slave modport is the arbiter's view of the bundle.
interface rob_wb_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32
) ();
  logic                    alu_wb_valid;
  logic                    alu_wb_ready;
  logic [ROB_ID_WIDTH-1:0] alu_wb_rob_id;
  logic [DATA_WIDTH-1:0]   alu_wb_reg_data;
  logic                    alu_wb_npc_valid;
  logic                    alu_wb_mispred;
  logic [ADDR_WIDTH-1:0]   alu_wb_npc;

  logic                    ld_wb_valid;
  logic                    ld_wb_ready;
  logic [ROB_ID_WIDTH-1:0] ld_wb_rob_id;
  logic [DATA_WIDTH-1:0]   ld_wb_reg_data;

  logic                    rob_wb_ready;
  logic                    rob_wb_valid;
  logic                    rob_wb_src;
  logic [ROB_ID_WIDTH-1:0] rob_wb_rob_id;
  logic [DATA_WIDTH-1:0]   rob_wb_reg_data;
  logic                    rob_wb_npc_valid;
  logic                    rob_wb_mispred;
  logic [ADDR_WIDTH-1:0]   rob_wb_npc;

  modport slave (
    input  alu_wb_valid, alu_wb_rob_id, alu_wb_reg_data, alu_wb_npc_valid,
           alu_wb_mispred, alu_wb_npc,
    input  ld_wb_valid, ld_wb_rob_id, ld_wb_reg_data,
    input  rob_wb_ready,
    output alu_wb_ready, ld_wb_ready,
    output rob_wb_valid, rob_wb_src, rob_wb_rob_id, rob_wb_reg_data,
           rob_wb_npc_valid, rob_wb_mispred, rob_wb_npc
  );

  modport master (
    output alu_wb_valid, alu_wb_rob_id, alu_wb_reg_data, alu_wb_npc_valid,
           alu_wb_mispred, alu_wb_npc,
    output ld_wb_valid, ld_wb_rob_id, ld_wb_reg_data,
    output rob_wb_ready,
    input  alu_wb_ready, ld_wb_ready,
    input  rob_wb_valid, rob_wb_src, rob_wb_rob_id, rob_wb_reg_data,
           rob_wb_npc_valid, rob_wb_mispred, rob_wb_npc
  );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Shares the single ROB writeback port between ALU and load writebacks.
// Each source has a 2-entry FIFO; loads win unless the ALU has been starved.
module rob_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_sH,
  input  logic                  flush,
  rob_wb_arbiter_if.slave       wb
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [DATA_WIDTH-1:0]   data;
    logic                    npc_valid;
    logic                    mispred;
    logic [ADDR_WIDTH-1:0]   npc;
  } alu_ent_t;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [DATA_WIDTH-1:0]   data;
  } ld_ent_t;

  alu_ent_t alu_mem_q [2];
  ld_ent_t  ld_mem_q  [2];

  logic          alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [1:0]    alu_cnt_q, alu_cnt_d;
  logic          ld_wr_q, ld_wr_d, ld_rd_q, ld_rd_d;
  logic [1:0]    ld_cnt_q, ld_cnt_d;
  logic [SW-1:0] starve_q, starve_d;

  logic     alu_rdy, ld_rdy, alu_ne, ld_ne;
  logic     alu_enq, ld_enq, alu_deq, ld_deq;
  logic     starved, grant_ld, grant_alu, out_valid;
  alu_ent_t alu_head;
  ld_ent_t  ld_head;

  // Ready looks only at the registered count, so a full queue never passes through.
  assign alu_rdy   = (alu_cnt_q != 2'd2) & ~flush & ~rst_sH;
  assign ld_rdy    = (ld_cnt_q  != 2'd2) & ~flush & ~rst_sH;
  assign alu_ne    = (alu_cnt_q != 2'd0);
  assign ld_ne     = (ld_cnt_q  != 2'd0);
  assign alu_enq   = wb.alu_wb_valid & alu_rdy;
  assign ld_enq    = wb.ld_wb_valid  & ld_rdy;

  assign starved   = alu_ne & (starve_q == SW'(STARVE_LIMIT));
  assign grant_ld  = ld_ne & ~starved;
  assign grant_alu = alu_ne & ~grant_ld;
  assign out_valid = (alu_ne | ld_ne) & ~flush & ~rst_sH;
  assign alu_deq   = out_valid & grant_alu & wb.rob_wb_ready;
  assign ld_deq    = out_valid & grant_ld  & wb.rob_wb_ready;

  assign alu_head  = alu_mem_q[alu_rd_q];
  assign ld_head   = ld_mem_q[ld_rd_q];

  assign wb.alu_wb_ready = alu_rdy;
  assign wb.ld_wb_ready  = ld_rdy;

  always_comb begin
    alu_wr_d  = alu_wr_q;
    alu_rd_d  = alu_rd_q;
    alu_cnt_d = alu_cnt_q;
    ld_wr_d   = ld_wr_q;
    ld_rd_d   = ld_rd_q;
    ld_cnt_d  = ld_cnt_q;
    starve_d  = starve_q;

    if (alu_enq) alu_wr_d = ~alu_wr_q;
    if (alu_deq) alu_rd_d = ~alu_rd_q;
    case ({alu_enq, alu_deq})
      2'b10:   alu_cnt_d = alu_cnt_q + 2'd1;
      2'b01:   alu_cnt_d = alu_cnt_q - 2'd1;
      default: alu_cnt_d = alu_cnt_q;
    endcase

    if (ld_enq) ld_wr_d = ~ld_wr_q;
    if (ld_deq) ld_rd_d = ~ld_rd_q;
    case ({ld_enq, ld_deq})
      2'b10:   ld_cnt_d = ld_cnt_q + 2'd1;
      2'b01:   ld_cnt_d = ld_cnt_q - 2'd1;
      default: ld_cnt_d = ld_cnt_q;
    endcase

    // Count only lost arbitrations that actually retired a load.
    if (!alu_ne || alu_deq) begin
      starve_d = '0;
    end else if (ld_deq && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    if (flush) begin
      alu_wr_d  = 1'b0;
      alu_rd_d  = 1'b0;
      alu_cnt_d = 2'd0;
      ld_wr_d   = 1'b0;
      ld_rd_d   = 1'b0;
      ld_cnt_d  = 2'd0;
      starve_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sH) begin
      alu_wr_q  <= 1'b0;
      alu_rd_q  <= 1'b0;
      alu_cnt_q <= 2'd0;
      ld_wr_q   <= 1'b0;
      ld_rd_q   <= 1'b0;
      ld_cnt_q  <= 2'd0;
      starve_q  <= '0;
    end else begin
      alu_wr_q  <= alu_wr_d;
      alu_rd_q  <= alu_rd_d;
      alu_cnt_q <= alu_cnt_d;
      ld_wr_q   <= ld_wr_d;
      ld_rd_q   <= ld_rd_d;
      ld_cnt_q  <= ld_cnt_d;
      starve_q  <= starve_d;
    end
  end

  // Storage needs no reset: the counts alone decide what is visible.
  always_ff @(posedge clk) begin
    if (alu_enq) begin
      alu_mem_q[alu_wr_q] <= '{rob_id:    wb.alu_wb_rob_id,
                               data:      wb.alu_wb_reg_data,
                               npc_valid: wb.alu_wb_npc_valid,
                               mispred:   wb.alu_wb_mispred,
                               npc:       wb.alu_wb_npc};
    end
    if (ld_enq) begin
      ld_mem_q[ld_wr_q] <= '{rob_id: wb.ld_wb_rob_id,
                             data:   wb.ld_wb_reg_data};
    end
  end

  always_comb begin
    wb.rob_wb_valid     = out_valid;
    wb.rob_wb_src       = 1'b0;
    wb.rob_wb_rob_id    = '0;
    wb.rob_wb_reg_data  = '0;
    wb.rob_wb_npc_valid = 1'b0;
    wb.rob_wb_mispred   = 1'b0;
    wb.rob_wb_npc       = '0;
    if (out_valid) begin
      if (grant_ld) begin
        wb.rob_wb_src      = 1'b1;
        wb.rob_wb_rob_id   = ld_head.rob_id;
        wb.rob_wb_reg_data = ld_head.data;
      end else if (grant_alu) begin
        wb.rob_wb_rob_id    = alu_head.rob_id;
        wb.rob_wb_reg_data  = alu_head.data;
        wb.rob_wb_npc_valid = alu_head.npc_valid;
        wb.rob_wb_mispred   = alu_head.mispred;
        wb.rob_wb_npc       = alu_head.npc;
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: inputs change just after each rising
// edge and outputs are sampled on the following falling edge.
module tb_rob_wb_arbiter;

  logic clk;
  logic rst_sH;
  logic flush;
  int   errCount;
  int   checkCount;

  rob_wb_arbiter_if #(.DATA_WIDTH(32), .ROB_ID_WIDTH(4), .ADDR_WIDTH(32)) bus ();

  rob_wb_arbiter #(
    .DATA_WIDTH(32), .ROB_ID_WIDTH(4), .ADDR_WIDTH(32), .STARVE_LIMIT(3)
  ) dut (
    .clk   (clk),
    .rst_sH(rst_sH),
    .flush (flush),
    .wb    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic aluV, input logic [3:0] aluId, input logic [31:0] aluData,
    input logic npcV, input logic mis, input logic [31:0] npc,
    input logic ldV, input logic [3:0] ldId, input logic [31:0] ldData,
    input logic robRdy, input logic fl, input logic rs);
    bus.alu_wb_valid     = aluV;
    bus.alu_wb_rob_id    = aluId;
    bus.alu_wb_reg_data  = aluData;
    bus.alu_wb_npc_valid = npcV;
    bus.alu_wb_mispred   = mis;
    bus.alu_wb_npc       = npc;
    bus.ld_wb_valid      = ldV;
    bus.ld_wb_rob_id     = ldId;
    bus.ld_wb_reg_data   = ldData;
    bus.rob_wb_ready     = robRdy;
    flush                = fl;
    rst_sH               = rs;
    @(negedge clk);
  endtask

  task automatic idle(input logic robRdy);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, robRdy, 0, 0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBus(input string tag, input logic v, input logic src,
                          input logic [3:0] id, input logic [31:0] data,
                          input logic npcV, input logic mis, input logic [31:0] npc);
    checkOutput({tag, ".valid"},     64'(bus.rob_wb_valid),     64'(v));
    checkOutput({tag, ".src"},       64'(bus.rob_wb_src),       64'(src));
    checkOutput({tag, ".rob_id"},    64'(bus.rob_wb_rob_id),    64'(id));
    checkOutput({tag, ".data"},      64'(bus.rob_wb_reg_data),  64'(data));
    checkOutput({tag, ".npc_valid"}, 64'(bus.rob_wb_npc_valid), 64'(npcV));
    checkOutput({tag, ".mispred"},   64'(bus.rob_wb_mispred),   64'(mis));
    checkOutput({tag, ".npc"},       64'(bus.rob_wb_npc),       64'(npc));
  endtask

  task automatic checkReady(input string tag, input logic aluR, input logic ldR);
    checkOutput({tag, ".alu_ready"}, 64'(bus.alu_wb_ready), 64'(aluR));
    checkOutput({tag, ".ld_ready"},  64'(bus.ld_wb_ready),  64'(ldR));
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;

    // Reset with requests present: nothing is accepted or presented.
    applyStimulus(1, 4'hF, 32'hFFFF, 1, 1, 32'hFF, 1, 4'hE, 32'hEEEE, 1, 0, 1);
    checkReady("rst0", 0, 0);
    checkBus("rst0", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    nextCycle();

    // Test 1: single ALU writeback with branch info.
    applyStimulus(1, 4'd5, 32'hDEAD, 1, 1, 32'h1000, 0, 0, 0, 1, 0, 0);
    checkReady("t1.accept", 1, 1);
    checkBus("t1.empty", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(1);
    checkBus("t1.out", 1, 0, 4'd5, 32'hDEAD, 1, 1, 32'h1000);
    nextCycle();
    idle(1);
    checkBus("t1.drained", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Test 2: simultaneous ALU and LD, load goes first.
    applyStimulus(1, 4'd2, 32'h22, 0, 0, 32'h2000, 1, 4'd3, 32'h33, 1, 0, 0);
    checkBus("t2.empty", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(1);
    checkBus("t2.ld", 1, 1, 4'd3, 32'h33, 0, 0, 0);
    nextCycle();
    idle(1);
    checkBus("t2.alu", 1, 0, 4'd2, 32'h22, 0, 0, 32'h2000);
    nextCycle();
    idle(1);
    checkOutput("t2.done.valid", 64'(bus.rob_wb_valid), 64'(0));
    nextCycle();

    // Test 3: steady load stream starves a single ALU entry until the limit.
    applyStimulus(1, 4'd7, 32'h77, 0, 0, 0, 1, 4'h0, 32'h100, 1, 0, 0);
    nextCycle();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'(i), 32'h100 + 32'(i), 1, 0, 0);
      checkBus($sformatf("t3.ld%0d", i), 1, 1, 4'(i - 1), 32'h100 + 32'(i - 1), 0, 0, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd4, 32'h104, 1, 0, 0);
    checkBus("t3.alu", 1, 0, 4'd7, 32'h77, 0, 0, 0);
    checkReady("t3.alu", 1, 1);
    nextCycle();
    idle(1);
    checkBus("t3.resume", 1, 1, 4'd3, 32'h103, 0, 0, 0);
    checkReady("t3.resume", 1, 0);
    nextCycle();
    idle(1);
    checkBus("t3.last", 1, 1, 4'd4, 32'h104, 0, 0, 0);
    nextCycle();
    idle(1);
    checkOutput("t3.done.valid", 64'(bus.rob_wb_valid), 64'(0));
    nextCycle();

    // Test 4: ROB stall with ALU backpressure.
    applyStimulus(1, 4'd1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkReady("t4.c1", 1, 1);
    nextCycle();
    applyStimulus(1, 4'd2, 32'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkReady("t4.c2", 1, 1);
    checkBus("t4.c2", 1, 0, 4'd1, 32'h11, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 4'd3, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkReady("t4.c3", 0, 1);
    checkBus("t4.c3", 1, 0, 4'd1, 32'h11, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 4'd3, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkReady("t4.c4", 0, 1);
    checkBus("t4.c4", 1, 0, 4'd1, 32'h11, 0, 0, 0);
    nextCycle();
    idle(1);
    checkReady("t4.rel", 0, 1);
    checkBus("t4.rel", 1, 0, 4'd1, 32'h11, 0, 0, 0);
    nextCycle();
    idle(1);
    checkReady("t4.second", 1, 1);
    checkBus("t4.second", 1, 0, 4'd2, 32'h12, 0, 0, 0);
    nextCycle();
    idle(1);
    checkOutput("t4.done.valid", 64'(bus.rob_wb_valid), 64'(0));
    nextCycle();

    // Test 5: fill both queues, then flush with new requests pending.
    applyStimulus(1, 4'd4, 32'h44, 0, 0, 0, 1, 4'hA, 32'hAA, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 4'd5, 32'h55, 0, 0, 0, 1, 4'hB, 32'hBB, 0, 0, 0);
    nextCycle();
    idle(0);
    checkReady("t5.full", 0, 0);
    checkBus("t5.full", 1, 1, 4'hA, 32'hAA, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 4'd6, 32'h66, 1, 1, 32'h6000, 1, 4'hC, 32'hCC, 1, 1, 0);
    checkReady("t5.flush", 0, 0);
    checkBus("t5.flush", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(1);
    checkReady("t5.after", 1, 1);
    checkBus("t5.after", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(1);
    checkOutput("t5.after2.valid", 64'(bus.rob_wb_valid), 64'(0));
    nextCycle();

    // Test 6: reset mid-operation discards queued entries.
    applyStimulus(1, 4'd1, 32'h101, 0, 0, 0, 1, 4'd2, 32'h202, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 4'd3, 32'h303, 1, 1, 32'h3000, 0, 0, 0, 1, 0, 1);
    checkReady("t6.rst", 0, 0);
    checkBus("t6.rst", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd9, 32'h99, 1, 0, 0);
    checkReady("t6.fresh", 1, 1);
    checkBus("t6.empty", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(1);
    checkBus("t6.ld9", 1, 1, 4'd9, 32'h99, 0, 0, 0);
    nextCycle();
    idle(1);
    checkOutput("t6.done.valid", 64'(bus.rob_wb_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
